// File: rtl/ram_port_sequencer.sv
// ram_port_sequencer
//
// Valid/ready front end for one read-write port of a true dual-port RAM with
// a registered (one-cycle) read. Each accepted request becomes a single-cycle
// RAM access. Read data is captured into a 2-entry response queue, so
// downstream backpressure never drops a read that is already in flight.
//
// Optional feature macro: RAM_PORT_SEQUENCER_CLEAR_EN
//   defined   : after reset a CLEAR phase writes zero to every RAM word through
//               this port (DEPTH cycles, busy=1), then the block enters RUN.
//   undefined : reset goes straight to RUN, busy is tied low, and RAM contents
//               after reset are whatever the RAM holds.
//
// Ports
//   clock               port clock, all logic on the rising edge
//   resetn              asynchronous active-low reset
//   request_valid       request present
//   request_ready       request accepted when valid & ready at a rising edge
//   request_write       1 = write, 0 = read
//   request_address     word address (values >= DEPTH are not supported)
//   request_write_data  write data
//   response_valid      read data available at the queue head
//   response_ready      consumer takes the response when valid & ready
//   response_read_data  read data, in request order (0 when not valid)
//   ram_access_enable   to RAM port access enable
//   ram_write           to RAM port write select
//   ram_address         to RAM port address
//   ram_write_data      to RAM port write data
//   ram_read_data       from RAM port read data (registered, 1-cycle latency)
//   busy                clear sequence in progress

module ram_port_sequencer #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic                     request_write,
    input  logic [ADDRESS_WIDTH-1:0] request_address,
    input  logic [WIDTH-1:0]         request_write_data,
    output logic                     response_valid,
    input  logic                     response_ready,
    output logic [WIDTH-1:0]         response_read_data,
    output logic                     ram_access_enable,
    output logic                     ram_write,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [WIDTH-1:0]         ram_write_data,
    input  logic [WIDTH-1:0]         ram_read_data,
    output logic                     busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Read accepted at the previous edge; its data is on ram_read_data now.
    logic read_vld_p1;

    // Response queue: two entries, head at rd_ptr, next free slot at wr_ptr.
    logic [WIDTH-1:0] fifo_data_p2 [2];
    logic             fifo_wr_ptr_p2;
    logic             fifo_rd_ptr_p2;
    logic [1:0]       fifo_count_p2;

    logic       push;
    logic       pop;
    logic       read_accept;
    logic       read_room;
    logic [1:0] occupancy;

`ifdef RAM_PORT_SEQUENCER_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

    logic [ADDRESS_WIDTH-1:0] clear_address;
    logic                     clear_last;

    assign clear_last = (clear_address == LAST_ADDRESS);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clear_address <= '0;
        end else if (state == ST_CLEAR) begin
            clear_address <= clear_address + ADDRESS_WIDTH'(1);
        end
    end
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Slots a new read would need once this edge settles: entries already
    // queued plus the read landing now, minus the entry leaving now. The
    // invariant count + in-flight <= 2 keeps this from wrapping.
    assign pop       = response_valid & response_ready;
    assign push      = read_vld_p1;
    assign occupancy = fifo_count_p2 + {1'b0, read_vld_p1} - {1'b0, pop};
    assign read_room = ~occupancy[1];

    always_comb begin
        state_next        = state;
        busy              = 1'b0;
        request_ready     = 1'b0;
        ram_access_enable = 1'b0;
        ram_write         = 1'b0;
        ram_address       = '0;
        ram_write_data    = '0;
        case (state)
            ST_CLEAR: begin
`ifdef RAM_PORT_SEQUENCER_CLEAR_EN
                busy = 1'b1;
                // Held off while reset is asserted so no write escapes then.
                ram_access_enable = resetn;
                ram_write         = 1'b1;
                ram_address       = clear_address;
                if (clear_last) begin
                    state_next = ST_RUN;
                end
`else
                state_next = ST_RUN;
`endif
            end
            ST_RUN: begin
                // Writes never touch the queue, so they are always taken.
                request_ready     = request_write | read_room;
                ram_access_enable = request_valid & request_ready & resetn;
                ram_write         = request_write;
                ram_address       = request_address;
                ram_write_data    = request_write_data;
            end
        endcase
    end

    assign read_accept = ram_access_enable & ~ram_write;

    // ---- stage p1: read issued to RAM, data returns after this edge ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_vld_p1 <= 1'b0;
        end else begin
            read_vld_p1 <= read_accept;
        end
    end

    // ---- stage p2: RAM read data captured into the response queue ----
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fifo_wr_ptr_p2 <= 1'b0;
            fifo_rd_ptr_p2 <= 1'b0;
            fifo_count_p2  <= 2'd0;
        end else begin
            if (push) begin
                fifo_wr_ptr_p2 <= ~fifo_wr_ptr_p2;
            end
            if (pop) begin
                fifo_rd_ptr_p2 <= ~fifo_rd_ptr_p2;
            end
            fifo_count_p2 <= fifo_count_p2 + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data_p2[fifo_wr_ptr_p2] <= ram_read_data;
        end
    end

    // Storage is not reset; masking the head keeps the output at zero
    // whenever nothing valid is presented.
    assign response_valid     = (fifo_count_p2 != 2'd0);
    assign response_read_data = response_valid ? fifo_data_p2[fifo_rd_ptr_p2] : '0;

endmodule

// File: tb/tb_ram_port_sequencer.sv
module tb_ram_port_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic             request_valid;
    logic             request_ready;
    logic             request_write;
    logic [AW-1:0]    request_address;
    logic [WIDTH-1:0] request_write_data;
    logic             response_valid;
    logic             response_ready;
    logic [WIDTH-1:0] response_read_data;
    logic             ram_access_enable;
    logic             ram_write;
    logic [AW-1:0]    ram_address;
    logic [WIDTH-1:0] ram_write_data;
    logic [WIDTH-1:0] ram_read_data;
    logic             busy;

    always #5 clock = ~clock;

    ram_port_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .request_valid(request_valid),
        .request_ready(request_ready),
        .request_write(request_write),
        .request_address(request_address),
        .request_write_data(request_write_data),
        .response_valid(response_valid),
        .response_ready(response_ready),
        .response_read_data(response_read_data),
        .ram_access_enable(ram_access_enable),
        .ram_write(ram_write),
        .ram_address(ram_address),
        .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data),
        .busy(busy)
    );

    // RAM port with registered read.
    logic [WIDTH-1:0] mem [DEPTH];
    initial begin
        ram_read_data = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
    end
    always @(posedge clock) begin
        if (ram_access_enable) begin
            if (ram_write) mem[ram_address] <= ram_write_data;
            else           ram_read_data    <= mem[ram_address];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    logic [WIDTH-1:0] exp_q [$];
    int pop_cyc [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: every handshake is checked against the scoreboard.
    always @(negedge clock) begin
        if (resetn && response_valid && response_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_response: got 0x%0h, expected no response", response_read_data);
            end else begin
                check("response_data", response_read_data, exp_q.pop_front());
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Presents one request and returns just after the edge that accepts it,
    // leaving request_valid high so calls can run back-to-back.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data,
                         input logic [WIDTH-1:0] exp_data, output int waited);
        request_valid      = 1'b1;
        request_write      = wr;
        request_address    = addr;
        request_write_data = data;
        waited = 0;
        @(negedge clock);
        while (!request_ready && waited < 50) begin
            waited++;
            @(negedge clock);
        end
        if (!request_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL request_timeout: got ready=0 after %0d cycles, expected ready=1", waited);
        end else if (!wr) begin
            exp_q.push_back(exp_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        request_valid = 1'b0;
        request_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int t;
        resetn             = 1'b0;
        request_valid      = 1'b0;
        request_write      = 1'b0;
        request_address    = '0;
        request_write_data = '0;
        response_ready     = 1'b1;

        // Reset values
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_response_valid", response_valid, 0);
        check("reset_response_data", response_read_data, 0);
        check("reset_access_enable", ram_access_enable, 0);
`ifdef RAM_PORT_SEQUENCER_CLEAR_EN
        check("reset_busy", busy, 1);
        check("reset_request_ready", request_ready, 0);
`else
        check("reset_busy", busy, 0);
        check("reset_request_ready", request_ready, 1);
`endif
        @(posedge clock);
        #1 resetn = 1'b1;

`ifdef RAM_PORT_SEQUENCER_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check("clear_busy", busy, 1);
            check("clear_enable", ram_access_enable, 1);
            check("clear_write", ram_write, 1);
            check("clear_address", ram_address, i);
            check("clear_data", ram_write_data, 0);
            check("clear_ready", request_ready, 0);
        end
        @(negedge clock);
        check("run_busy", busy, 0);
        check("run_ready", request_ready, 1);
        @(posedge clock);
        #1;
        issue(1'b0, 4'd5, 8'h00, 8'h00, w);
        idle();
        repeat (4) @(posedge clock);
        #1;
`else
        @(negedge clock);
        check("run_busy", busy, 0);
        check("run_ready", request_ready, 1);
        @(posedge clock);
        #1;
`endif

        // Write then read next cycle, 2-cycle response latency
        issue(1'b1, 4'd3, 8'hA5, 8'h00, w);
        issue(1'b0, 4'd3, 8'h00, 8'hA5, w);
        idle();
        @(negedge clock);
        check("latency_not_early", response_valid, 0);
        @(negedge clock);
        check("latency_valid", response_valid, 1);
        check("latency_data", response_read_data, 8'hA5);
        repeat (3) @(posedge clock);
        #1;

        // Back-to-back reads with full throughput
        for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 8'(8'h10 + i), 8'h00, w);
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, AW'(i), 8'h00, 8'(8'h10 + i), w);
            check("b2b_ready", w, 0);
        end
        idle();
        repeat (5) @(posedge clock);
        #1;
        check("b2b_count", pop_cyc.size(), 8);
        for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
            check("b2b_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);

        // Backpressure stalls the third read
        response_ready = 1'b0;
        issue(1'b0, 4'd1, 8'h00, 8'h11, w);
        check("bp_first_accept", w, 0);
        issue(1'b0, 4'd2, 8'h00, 8'h12, w);
        check("bp_second_accept", w, 0);
        request_address = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("bp_third_stalled", request_ready, 0);
            check("bp_head_valid", response_valid, 1);
            check("bp_head_data", response_read_data, 8'h11);
        end
        @(posedge clock);
        #1 response_ready = 1'b1;
        issue(1'b0, 4'd3, 8'h00, 8'h13, w);
        check("bp_third_on_release", w, 0);
        idle();
        repeat (5) @(posedge clock);
        #1;

        // Write accepted while the queue is full
        response_ready = 1'b0;
        issue(1'b0, 4'd4, 8'h00, 8'h14, w);
        issue(1'b0, 4'd5, 8'h00, 8'h15, w);
        idle();
        repeat (3) @(posedge clock);
        #1;
        issue(1'b1, 4'd9, 8'h3C, 8'h00, w);
        check("full_write_accepted", w, 0);
        idle();
        check("full_write_ram", mem[9], 8'h3C);
        @(negedge clock);
        check("full_head_valid", response_valid, 1);
        check("full_head_unchanged", response_read_data, 8'h14);
        @(posedge clock);
        #1 response_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        issue(1'b0, 4'd9, 8'h00, 8'h3C, w);
        idle();
        repeat (4) @(posedge clock);
        #1;

        // Reset while one entry is queued and a read is in flight
        response_ready = 1'b0;
        issue(1'b0, 4'd6, 8'h00, 8'h16, w);
        issue(1'b0, 4'd7, 8'h00, 8'h17, w);
        idle();
        resetn = 1'b0;
        #1;
        check("midreset_valid", response_valid, 0);
        check("midreset_data", response_read_data, 0);
        exp_q.delete();
        response_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        t = 0;
        @(negedge clock);
        while (busy && t < 100) begin
            t++;
            @(negedge clock);
        end
        check("midreset_busy_done", busy, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("midreset_no_stale", response_valid, 0);
        end
        @(posedge clock);
        #1;
`ifdef RAM_PORT_SEQUENCER_CLEAR_EN
        issue(1'b0, 4'd7, 8'h00, 8'h00, w);
`else
        issue(1'b0, 4'd7, 8'h00, 8'h17, w);
`endif
        idle();
        repeat (5) @(posedge clock);
        #1;
        check("all_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
